// File: rtl/anemo_freq_meter.sv
// Anemometer pulse-frequency meter: counts synchronized rising edges over a fixed gate window
// and publishes a saturated 8-bit result. Define ANEMO_DEBOUNCE_EN to insert an input glitch filter.
module anemo_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned DEB_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_freq_anemometre,
  input  logic       continu,
  input  logic       start_stop,
  output logic [7:0] data_anemometre,
  output logic       data_valid,
  output logic [2:0] status
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 4 || DEB_CYCLES < 2) begin : g_param_check
    $error("anemo_freq_meter: GATE_CYCLES must be >= 4 and DEB_CYCLES >= 2");
  end

  typedef enum logic [1:0] {StIdle, StGate, StDone} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic            lvl_q;
  logic            level;
  logic            pulse;
  logic            ss_q, ss_rise_q;
  logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
  logic [15:0]     edge_cnt_q, edge_cnt_d;
  logic [15:0]     cnt_incl;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            busy_q, busy_d;

`ifdef ANEMO_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYCLES);

  logic          filt_q, filt_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;

  // The filtered level follows only after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q    <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign pulse    = level & ~lvl_q;
  assign cnt_incl = (pulse && edge_cnt_q != 16'hFFFF) ? edge_cnt_q + 16'd1 : edge_cnt_q;

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        if (continu || ss_rise_q) state_d = StGate;
      end
      StGate: begin
        if (gate_cnt_q == GateLast) begin
          // An edge seen on the terminal cycle belongs to the closing window.
          data_d     = (|cnt_incl[15:8]) ? 8'hFF : cnt_incl[7:0];
          ovf_d      = |cnt_incl[15:8];
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          state_d    = continu ? StGate : StDone;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = cnt_incl;
        end
      end
      StDone: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        if (continu) begin
          state_d = StGate;
        end else if (!start_stop) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StGate);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lvl_q      <= 1'b0;
      ss_q       <= 1'b0;
      ss_rise_q  <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= in_freq_anemometre;
      sync2_q    <= sync1_q;
      lvl_q      <= level;
      ss_q       <= start_stop;
      ss_rise_q  <= start_stop & ~ss_q;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign data_anemometre = data_q;
  assign data_valid      = valid_q;
  assign status          = {ovf_q, busy_q, valid_q};

endmodule

// File: tb/tb_anemo_freq_meter.sv
// Self-checking bench for anemo_freq_meter: table vectors, corner sequences and random periods
// checked against an edge-timestamp reference model.
module tb_anemo_freq_meter;

  localparam int GATE = 1000;
  localparam int DEB  = 8;
`ifdef ANEMO_DEBOUNCE_EN
  localparam int LAT  = 3 + DEB;
  localparam int HOLD = DEB + 4;
  localparam int SSP  = 40;
  localparam int PMIN = 20;
  localparam int PMAX = 80;
  localparam int CP   = 20;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 4;
  localparam int SSP  = 20;
  localparam int PMIN = 4;
  localparam int PMAX = 40;
  localparam int CP   = 10;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ain;
  logic       continu;
  logic       start_stop;
  logic [7:0] data;
  logic       data_valid;
  logic [2:0] status;

  anemo_freq_meter #(
    .GATE_CYCLES(GATE),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_freq_anemometre(ain),
    .continu           (continu),
    .start_stop        (start_stop),
    .data_anemometre   (data),
    .data_valid        (data_valid),
    .status            (status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         per;
    bit         gl;
    int         exp_data;
    logic [2:0] exp_status;
  } vec_t;

  vec_t tbl[4];
  int   per = 0;
  int   ph = 0;
  bit   man = 1'b0;
  bit   glitch_en = 1'b0;
  int   rises[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   g;
  int   c;
  int   s;
  int   m;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, then drive the next input sample and log real (non-glitch) rises.
  task automatic tick();
    bit nv;
    bit gl;
    @(posedge clk);
    #1;
    gl = 1'b0;
    if (per > 0) begin
      ph = (ph + 1) % per;
      nv = (ph < per / 2);
      if (glitch_en && ph >= per / 2 + per / 4 && ph < per / 2 + per / 4 + 5) begin
        nv = 1'b1;
        gl = 1'b1;
      end
    end else begin
      nv = man;
    end
    if (nv && !ain && !gl) rises.push_back(cyc);
    ain = nv;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Switch pattern only at the end of a full low phase so no pulse is truncated.
  task automatic set_per(input int p, input bit gle);
    if (per > 0) while (ph != per - 1) tick();
    per       = p;
    ph        = (p > 0) ? p - 1 : 0;
    glitch_en = gle;
  endtask

  // Edges counted in the window entered at edge w: those whose count edge lies in [w+1, w+GATE].
  function automatic int model(input int w);
    int cnt = 0;
    foreach (rises[i]) begin
      if (rises[i] + LAT >= w + 1 && rises[i] + LAT <= w + GATE) cnt++;
    end
    return cnt;
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ANEMO_DEBOUNCE_EN
    tbl[0] = '{40, 1'b1, 25, 3'b011};
    tbl[1] = '{50, 1'b0, 20, 3'b011};
    tbl[2] = '{20, 1'b0, 50, 3'b011};
    tbl[3] = '{100, 1'b1, 10, 3'b011};
`else
    tbl[0] = '{10, 1'b0, 100, 3'b011};
    tbl[1] = '{25, 1'b0, 40, 3'b011};
    tbl[2] = '{2, 1'b0, 255, 3'b111};
    tbl[3] = '{20, 1'b0, 50, 3'b011};
`endif
    reset_n    = 1'b0;
    ain        = 1'b0;
    continu    = 1'b0;
    start_stop = 1'b0;

    // Reset held while the input toggles
    set_per(4, 1'b0);
    ticks(20);
    chk("reset data", data, 0);
    chk("reset status", status, 0);
    chk("reset valid", data_valid, 0);
    set_per(0, 1'b0);
    man = 1'b0;
    ticks(20);
    rises.delete();
    reset_n = 1'b1;
    ticks(5);
    chk("idle busy", status[1], 0);

    // Single-shot
    set_per(SSP, 1'b0);
    ticks(7);
    start_stop = 1'b1;
    s = cyc;
    g = s + 2;
    tick();
    chk("ss busy +1", status[1], 0);
    tick();
    chk("ss busy +2", status[1], 1);
    wait_until(g + GATE - 1);
    chk("ss busy last", status[1], 1);
    chk("ss valid during", data_valid, 0);
    tick();
    chk("ss data", data, GATE / SSP);
    chk("ss model", data, sat(model(g)));
    chk("ss status", status, 3'b001);
    ticks(5);
    chk("ss done held", status, 3'b001);
    start_stop = 1'b0;
    tick();
    chk("ss valid clr", data_valid, 0);
    chk("ss data kept", data, GATE / SSP);

    // Continuous, table-driven periods
    continu = 1'b1;
    c = cyc;
    g = c + 1;
    tick();
    chk("cont busy +1", status[1], 1);
    for (int i = 0; i < 4; i++) begin
      set_per(tbl[i].per, tbl[i].gl);
      wait_until(g + GATE);
      chk($sformatf("tbl%0d transition model", i), data, sat(model(g)));
      chk($sformatf("tbl%0d no gap", i), status[1], 1);
      g += GATE;
      wait_until(g + GATE);
      chk($sformatf("tbl%0d data", i), data, tbl[i].exp_data);
      chk($sformatf("tbl%0d status", i), status, tbl[i].exp_status);
      chk($sformatf("tbl%0d model", i), data, sat(model(g)));
      g += GATE;
    end

    // Random periods changed at random points inside windows
    for (int k = 0; k < 6; k++) begin
      wait_until(g + int'($urandom_range(0, GATE - 150)));
      set_per(int'($urandom_range(PMIN, PMAX)), 1'b0);
      wait_until(g + GATE);
      m = model(g);
      chk($sformatf("rnd%0d data", k), data, sat(m));
      chk($sformatf("rnd%0d ovf", k), status[2], (m > 255) ? 1 : 0);
      g += GATE;
    end

    // Edge on the terminal cycle, then one cycle too late
    set_per(0, 1'b0);
    man = 1'b0;
    wait_until(g + GATE);
    chk("quiet model", data, sat(model(g)));
    g += GATE;
    wait_until(g + GATE - LAT - 1);
    man = 1'b1;
    tick();
    wait_until(g + GATE);
    chk("terminal edge", data, 1);
    ticks(HOLD);
    man = 1'b0;
    g += GATE;
    wait_until(g + GATE - LAT);
    man = 1'b1;
    tick();
    wait_until(g + GATE);
    chk("late edge excluded", data, 0);
    ticks(HOLD);
    man = 1'b0;
    g += GATE;

    // continu dropped mid-window with start_stop held: publish, then park in DONE
    start_stop = 1'b1;
    ticks(100);
    continu = 1'b0;
    wait_until(g + GATE);
    chk("drop data", data, 1);
    chk("drop status", status, 3'b001);
    ticks(3);
    chk("done held", status, 3'b001);
    start_stop = 1'b0;
    tick();
    chk("idle after done", status, 3'b000);

    // continu and start_stop rise together: continuous wins
    set_per(CP, 1'b0);
    ticks(20);
    continu    = 1'b1;
    start_stop = 1'b1;
    c = cyc;
    g = c + 1;
    tick();
    chk("both busy +1", status[1], 1);
    start_stop = 1'b0;
    wait_until(g + GATE);
    chk("both data", data, GATE / CP);
    chk("both model", data, sat(model(g)));
    chk("both still busy", status[1], 1);
    g += GATE;

    // Asynchronous reset mid-window
    wait_until(g + 300);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async rst data", data, 0);
    chk("async rst status", status, 0);
    chk("async rst valid", data_valid, 0);
    continu = 1'b0;
    ticks(3);
    reset_n = 1'b1;
    ticks(5);
    chk("post rst idle", status[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
